simd_serial_alu: RTL and testbench

SIMD_SERIAL_ALU -- requirements
Module: simd_serial_alu

---
 rtl/simd_serial_alu.sv | 85 ++++++++
 tb/tb_simd_serial_alu.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/simd_serial_alu.sv
// simd_serial_alu: nibble-serial SIMD add/sub with lane saturation; ports clk/rst_n, in_valid/in_ready + a,b,sub,saturate,width request, out_valid/out_ready + result,overflow response
module simd_serial_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  input  logic        saturate,
  input  logic [1:0]  width,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic [3:0]  overflow
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, OUT} state_t;
  state_t state_q, state_d;
  logic [1:0] cnt_q, w_q;
  logic carry_q, sub_q, sat_q;
  logic [15:0] a_q, b_q, sum_q, fix_d;
  logic [3:0] ovf_q, an, bn, s3;
  logic [4:0] full;
  logic lowest, top, cin;
  always_comb begin
    an = a_q[{cnt_q, 2'b00} +: 4];
    bn = b_q[{cnt_q, 2'b00} +: 4] ^ {4{sub_q}};
    lowest = (w_q == 2'b00) | (w_q == 2'b01 & ~cnt_q[0]) | (w_q[1] & cnt_q == 2'd0);
    top = (w_q == 2'b00) | (w_q == 2'b01 & cnt_q[0]) | (w_q[1] & cnt_q == 2'd3);
    cin = lowest ? sub_q : carry_q;
    s3 = {1'b0, an[2:0]} + {1'b0, bn[2:0]} + {3'b0, cin};
    full = {1'b0, an} + {1'b0, bn} + {4'b0, cin};
    state_d = state_q == IDLE ? (in_valid ? CALC : IDLE) :
              state_q == CALC ? (cnt_q == 2'd3 ? FIX : CALC) :
              state_q == FIX  ? OUT : (out_ready ? IDLE : OUT);
  end
  for (genvar g = 0; g < 4; g++) begin : g_fix
    localparam logic [1:0] G = g;
    logic [1:0] t;
    logic neg;
    assign t = w_q == 2'b00 ? G : w_q == 2'b01 ? (G | 2'b01) : 2'd3;
    assign neg = a_q[{t, 2'b11}];
    assign fix_d[4*g +: 4] = sat_q & ovf_q[t] ? (t == G ? {neg, {3{~neg}}} : {4{~neg}}) : sum_q[4*g +: 4];
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == OUT;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      carry_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      sub_q <= 1'b0;
      sat_q <= 1'b0;
      w_q <= '0;
      sum_q <= '0;
      ovf_q <= '0;
      result <= '0;
      overflow <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) begin
        a_q <= a;
        b_q <= b;
        sub_q <= sub;
        sat_q <= saturate;
        w_q <= width[1] ? 2'b10 : width;
        cnt_q <= '0;
        carry_q <= 1'b0;
        ovf_q <= '0;
      end
      if (state_q == CALC) begin
        sum_q[{cnt_q, 2'b00} +: 4] <= full[3:0];
        carry_q <= full[4];
        ovf_q[cnt_q] <= top & (s3[3] ^ full[4]);
        cnt_q <= cnt_q + 2'd1;
      end
      if (state_q == FIX) begin
        result <= fix_d;
        overflow <= ovf_q;
      end
    end
  end
endmodule

// File: tb/tb_simd_serial_alu.sv
// tb_simd_serial_alu: directed and random checks of simd_serial_alu against a lane-arithmetic model
module tb_simd_serial_alu;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, sub = 1'b0, saturate = 1'b0, out_ready = 1'b1;
  logic [15:0] a = '0, b = '0;
  logic [1:0] width = '0;
  logic in_ready, out_valid;
  logic [15:0] result;
  logic [3:0] overflow;
  int checks = 0, failures = 0;
  simd_serial_alu dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .saturate(saturate), .width(width),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [19:0] model(input logic [15:0] ma, input logic [15:0] mb, input logic ms,
                                        input logic msat, input logic [1:0] mw);
    int l, mask, sa, sb, r, mx, mn;
    logic [15:0] res;
    logic [3:0] ov;
    l = mw == 2'd0 ? 4 : mw == 2'd1 ? 8 : 16;
    mask = (1 << l) - 1;
    mx = (1 << (l - 1)) - 1;
    mn = -(1 << (l - 1));
    res = '0;
    ov = '0;
    for (int lo = 0; lo < 16; lo += l) begin
      sa = (int'(ma) >> lo) & mask;
      sb = (int'(mb) >> lo) & mask;
      if (sa > mx) sa -= (1 << l);
      if (sb > mx) sb -= (1 << l);
      r = ms ? sa - sb : sa + sb;
      if (r > mx || r < mn) begin
        ov[(lo + l) / 4 - 1] = 1'b1;
        if (msat) r = r > mx ? mx : mn;
      end
      res = res | 16'((r & mask) << lo);
    end
    return {ov, res};
  endfunction
  task automatic issue(input logic [15:0] ta, input logic [15:0] tb2, input logic ts, input logic tsat,
                       input logic [1:0] tw);
    a = ta;
    b = tb2;
    sub = ts;
    saturate = tsat;
    width = tw;
    in_valid = 1'b1;
  endtask
  task automatic finish_op(input logic [19:0] exp, input int hold);
    int n;
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    sub = 1'($urandom);
    saturate = 1'($urandom);
    width = 2'($urandom);
    chk("busy_in_ready", in_ready, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 5);
    chk("result", result, exp[15:0]);
    chk("overflow", overflow, exp[19:16]);
    if (hold > 0) begin
      out_ready = 1'b0;
      repeat (hold) begin
        in_valid = 1'($urandom);
        a = 16'($urandom);
        @(negedge clk);
        chk("hold_result", result, exp[15:0]);
        chk("hold_overflow", overflow, exp[19:16]);
        chk("hold_valid", out_valid, 1);
        chk("hold_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk("done_valid", out_valid, 0);
    chk("done_in_ready", in_ready, 1);
  endtask
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb2, input logic ts, input logic tsat,
                        input logic [1:0] tw, input logic [19:0] exp, input int hold);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait_in_ready", in_ready, 1);
    issue(ta, tb2, ts, tsat, tw);
    finish_op(exp, hold);
  endtask
  initial begin
    logic [15:0] ra, rb;
    logic rs, rsat;
    logic [1:0] rw;
    #1;
    chk("rst_result", result, 16'h0000);
    chk("rst_overflow", overflow, 4'b0000);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 2'b10, 20'h87FFF, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 2'b10, 20'h88000, 0);
    run_op(16'h7777, 16'h1111, 1'b0, 1'b1, 2'b00, 20'hF7777, 0);
    run_op(16'h7777, 16'h1111, 1'b0, 1'b0, 2'b00, 20'hF8888, 0);
    run_op(16'h8000, 16'h0100, 1'b1, 1'b1, 2'b01, 20'h88000, 0);
    run_op(16'h8000, 16'h0100, 1'b1, 1'b0, 2'b01, 20'h87F00, 0);
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 2'b00, 20'h02345, 0);
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 2'b10, 20'h02345, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 2'b11, 20'h88000, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 2'b10, 20'h87FFF, 10);
    @(negedge clk);
    issue(16'h1234, 16'h1111, 1'b0, 1'b0, 2'b00);
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_result", result, 16'h0000);
    chk("abort_overflow", overflow, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h8000, 16'h0100, 1'b1, 1'b1, 2'b01);
    finish_op(20'h88000, 0);
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      rsat = 1'($urandom);
      rw = 2'($urandom);
      run_op(ra, rb, rs, rsat, rw, model(ra, rb, rs, rsat, rw), int'($urandom_range(0, 2)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
